// File: rtl/button_pkg.sv
// Shared types for the push-button front end.
// AUTO_REPEAT_EN selects hold-to-repeat pulses in button_debouncer.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam logic BTN_PRESSED  = 1'b0;
    localparam logic BTN_RELEASED = 1'b1;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button: 2-flop sync, debounce FSM, single-cycle accept strobe.
// AUTO_REPEAT_EN adds hold-to-repeat strobes while PRESSED.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic hit
);

    localparam int CNT_W =
        cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       sync;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             pressed;
    logic             press_hit;

    assign pressed   = (sync[1] == BTN_PRESSED);
    assign cnt_nxt   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign press_hit = (state == PRESS_WAIT) && pressed && (cnt == DB_LAST);

`ifdef AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] HD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic rep;
    logic rep_hit;

    // first repeat waits HOLD_CYCLES, later ones REPEAT_CYCLES
    assign rep_hit = (state == PRESSED) && pressed &&
                     (cnt == (rep ? RP_LAST : HD_LAST));
    assign hit     = press_hit | rep_hit;
`else
    assign hit     = press_hit;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync  <= {BTN_RELEASED, BTN_RELEASED};
            state <= IDLE;
            cnt   <= '0;
`ifdef AUTO_REPEAT_EN
            rep   <= 1'b0;
`endif
        end else begin
            sync <= {sync[0], btn_n};
            unique case (state)
                IDLE: begin
                    if (pressed) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
`ifdef AUTO_REPEAT_EN
                        rep   <= 1'b0;
                    end else if (rep_hit) begin
                        cnt <= '0;
                        rep <= 1'b1;
                    end else begin
                        cnt <= cnt_nxt;
`endif
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Two debounced buttons -> mutually exclusive increment/decrease pulses.
// Build with AUTO_REPEAT_EN for hold-to-repeat behaviour.
module button_pulse_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_inc_n,
    input  logic btn_dec_n,
    output logic increment,
    output logic decrease
);

    logic inc_hit;
    logic dec_hit;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_inc (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_inc_n),
        .hit  (inc_hit)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .HOLD_CYCLES    (HOLD_CYCLES),
        .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_dec (
        .clk  (clk),
        .reset(reset),
        .btn_n(btn_dec_n),
        .hit  (dec_hit)
    );

    // coincident strobes cancel each other
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            increment <= 1'b0;
            decrease  <= 1'b0;
        end else begin
            increment <= inc_hit & ~dec_hit;
            decrease  <= dec_hit & ~inc_hit;
        end
    end

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Bench for button_pulse_conditioner: run-length reference model,
// vector table, directed corner sequences and random pin activity.
module tb_button_pulse_conditioner;

    localparam int D = 4;
    localparam int H = 20;
    localparam int R = 8;

`ifdef AUTO_REPEAT_EN
    localparam int T2_EXP = 2;
    localparam int T6_EXP = 4;
`else
    localparam int T2_EXP = 1;
    localparam int T6_EXP = 1;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic btn_inc_n = 1'b1;
    logic btn_dec_n = 1'b1;
    logic increment;
    logic decrease;

    always #5 clk = ~clk;

    button_pulse_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .HOLD_CYCLES    (H),
        .REPEAT_CYCLES  (R)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .btn_inc_n(btn_inc_n),
        .btn_dec_n(btn_dec_n),
        .increment(increment),
        .decrease (decrease)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_inc = 0;
    int n_dec = 0;
    int inc_edges[$];

    // reference model state: two-stage pin delay, accepted level,
    // length of the current disagreeing run, length of the current hold
    bit [1:0] sy_i, sy_d;
    bit       lvl[2];
    int       run[2];
    int       hold[2];
    bit       exp_inc, exp_dec;

    typedef struct {
        bit    inc_n;
        bit    dec_n;
        int    len;
        int    e_inc;
        int    e_dec;
        string name;
    } vec_t;

    vec_t vecs[$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic void mreset();
        sy_i = 2'b11;
        sy_d = 2'b11;
        for (int b = 0; b < 2; b++) begin
            lvl[b]  = 1'b0;
            run[b]  = 0;
            hold[b] = 0;
        end
        exp_inc = 1'b0;
        exp_dec = 1'b0;
    endfunction

    // a level is accepted after D+1 consecutive agreeing samples
    function automatic bit mbtn(int b, bit s);
        bit pr;
        bit p;
        pr = (s == 1'b0);
        p  = 1'b0;
        if (pr == lvl[b]) begin
            if (run[b] != 0) hold[b] = 0;
            else if (lvl[b]) hold[b]++;
            run[b] = 0;
`ifdef AUTO_REPEAT_EN
            if (lvl[b] && hold[b] >= H && (hold[b] - H) % R == 0) p = 1'b1;
`endif
        end else begin
            run[b]++;
            if (run[b] == D + 1) begin
                lvl[b]  = pr;
                run[b]  = 0;
                hold[b] = 0;
                p       = pr;
            end
        end
        return p;
    endfunction

    task automatic step();
        bit si, sd, pi, pd;
        @(posedge clk);
        cyc++;
        if (reset) begin
            si   = sy_i[1];
            sd   = sy_d[1];
            sy_i = {sy_i[0], btn_inc_n};
            sy_d = {sy_d[0], btn_dec_n};
            pi   = mbtn(0, si);
            pd   = mbtn(1, sd);
            exp_inc = pi && !pd;
            exp_dec = pd && !pi;
        end else begin
            mreset();
        end
        #1;
        check("increment", increment, exp_inc);
        check("decrease", decrease, exp_dec);
        check("mutex", increment & decrease, 0);
        if (increment === 1'b1) begin
            n_inc++;
            inc_edges.push_back(cyc);
        end
        if (decrease === 1'b1) n_dec++;
    endtask

    task automatic drive(bit i, bit d, int n);
        btn_inc_n = i;
        btn_dec_n = d;
        repeat (n) step();
    endtask

    task automatic clear_counts();
        n_inc = 0;
        n_dec = 0;
        inc_edges.delete();
    endtask

    initial begin
        int mark;
        int exp_e[4];
        exp_e = '{7, 27, 35, 43};
        mreset();

        vecs.push_back('{0, 1, 10, 1, 0, "v_inc10"});
        vecs.push_back('{1, 0, 10, 0, 1, "v_dec10"});
        vecs.push_back('{0, 1, 4, 0, 0, "v_inc4_short"});
        vecs.push_back('{0, 1, 5, 1, 0, "v_inc5_exact"});
        vecs.push_back('{1, 0, 4, 0, 0, "v_dec4_short"});
        vecs.push_back('{1, 0, 5, 0, 1, "v_dec5_exact"});
        vecs.push_back('{0, 0, 10, 0, 0, "v_both"});
        vecs.push_back('{1, 0, 20, 0, 1, "v_dec20"});

        // 1: reset held with pins released
        repeat (3) step();
        reset = 1'b1;
        repeat (6) step();
        check("t1_quiet", n_inc + n_dec, 0);

        // 2: clean press, latency
        clear_counts();
        mark = cyc;
        drive(0, 1, 30);
        drive(1, 1, 12);
        check("t2_inc_count", n_inc, T2_EXP);
        check("t2_dec_count", n_dec, 0);
        if (inc_edges.size() > 0)
            check("t2_edge", inc_edges[0] - mark, 7);
        else
            check("t2_edge_missing", 0, 7);

        // 3: press bounce then steady
        clear_counts();
        repeat (3) begin
            drive(0, 1, 2);
            drive(1, 1, 2);
        end
        drive(0, 1, 10);
        drive(1, 1, 12);
        check("t3_inc_count", n_inc, 1);

        // 4: release bounce, second press
        clear_counts();
        drive(1, 0, 10);
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 1, 10);
        drive(1, 0, 10);
        drive(1, 1, 12);
        check("t4_dec_count", n_dec, 2);
        check("t4_inc_count", n_inc, 0);

        // 5: coincident presses, then hold across reset
        clear_counts();
        drive(0, 0, 10);
        drive(1, 1, 12);
        check("t5_both_pulses", n_inc + n_dec, 0);
        drive(0, 1, 8);
        reset = 1'b0;
        mreset();
        #1;
        check("t5_async_inc", increment, 0);
        clear_counts();
        drive(0, 1, 3);
        reset = 1'b1;
        drive(0, 1, 10);
        drive(1, 1, 12);
        check("t5_reheld_inc", n_inc, 1);

        // 6: long hold
        clear_counts();
        mark = cyc;
        drive(0, 1, 48);
        drive(1, 1, 12);
        check("t6_inc_count", n_inc, T6_EXP);
`ifdef AUTO_REPEAT_EN
        for (int k = 0; k < 4; k++)
            if (k < inc_edges.size())
                check("t6_edge", inc_edges[k] - mark, exp_e[k]);
`else
        if (inc_edges.size() > 0)
            check("t6_edge", inc_edges[0] - mark, exp_e[0]);
`endif

        // vector table
        foreach (vecs[v]) begin
            clear_counts();
            drive(vecs[v].inc_n, vecs[v].dec_n, vecs[v].len);
            drive(1, 1, 12);
            check({vecs[v].name, "_inc"}, n_inc, vecs[v].e_inc);
            check({vecs[v].name, "_dec"}, n_dec, vecs[v].e_dec);
        end

        // random pin activity against the model
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                reset = 1'b0;
                mreset();
                repeat (2) step();
                reset = 1'b1;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 12));
        end
        drive(1, 1, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
